// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and immediate helpers for the branch controller.
package rv_pkg;

    // Major opcodes handled by the redirect logic
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Conditional-branch funct3 codes (010/011 are reserved)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Squash counter width; SQUASH_CYC is limited to 1..7
    localparam int unsigned SQ_W = 3;

    typedef enum logic [0:0] {
        StIdle,
        StSquash
    } state_e;

    // B-type immediate, 13-bit signed byte offset
    function automatic logic [12:0] b_imm(input logic [31:0] insn);
        return {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    // J-type immediate, 21-bit signed byte offset
    function automatic logic [20:0] j_imm(input logic [31:0] insn);
        return {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Fetch/decode handshake between pc (master) and branch_ctrl (slave).
interface branch_ctrl_if #(
    parameter int unsigned LABEL_W = 13,
    parameter int unsigned CNT_W   = 16
);
    logic [31:0]        insn;
    logic               insn_valid;
    logic [31:0]        rs1_data;
    logic [31:0]        rs2_data;
    logic               branch;
    logic               jump;
    logic               zero;
    logic [LABEL_W-1:0] label;
    logic               flush;
    logic               illegal;
    logic               jal_oor;
    logic [CNT_W-1:0]   taken_cnt;

    modport master (
        output insn, insn_valid, rs1_data, rs2_data,
        input  branch, jump, zero, label, flush, illegal, jal_oor, taken_cnt
    );

    modport slave (
        input  insn, insn_valid, rs1_data, rs2_data,
        output branch, jump, zero, label, flush, illegal, jal_oor, taken_cnt
    );
endinterface

// File: rtl/branch_ctrl_cmp.sv
// Combinational RV32I branch condition evaluator.
module branch_cmp
    import rv_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        cond_o,
    output logic        illegal_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1_i == rs2_i);
    assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
    assign lt_u = (rs1_i < rs2_i);

    // Select the condition for funct3; reserved codes flag illegal
    always_comb begin
        cond_o    = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond_o = eq;
            F3_BNE:  cond_o = ~eq;
            F3_BLT:  cond_o = lt_s;
            F3_BGE:  cond_o = ~lt_s;
            F3_BLTU: cond_o = lt_u;
            F3_BGEU: cond_o = ~lt_u;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// Decode-side branch/JAL resolver: registers one redirect decision per accepted
// instruction and discards the wrong-path fetch slots after a taken redirect.
module branch_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned LABEL_W    = 13,
    parameter int unsigned SQUASH_CYC = 2,
    parameter int unsigned CNT_W      = 16
) (
    input logic           clk,
    input logic           rst,
    branch_ctrl_if.slave  bus
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_b;
    logic       is_jal;
    logic       is_jalr;
    logic       cmp_cond;
    logic       cmp_illegal;

    logic [12:0]        bi;
    logic [20:0]        ji;
    logic signed [31:0] j_sext;
    logic signed [31:0] j_hi;
    logic               j_fits;

    logic               dec_branch;
    logic               dec_zero;
    logic               dec_jump;
    logic               dec_illegal;
    logic               dec_oor;
    logic               dec_taken;
    logic [LABEL_W-1:0] dec_label;

    state_e             state_q;
    logic [SQ_W-1:0]    sq_cnt_q;
    logic               branch_q;
    logic               jump_q;
    logic               zero_q;
    logic               flush_q;
    logic               illegal_q;
    logic               jal_oor_q;
    logic [LABEL_W-1:0] label_q;
    logic [CNT_W-1:0]   taken_cnt_q;
    logic [CNT_W-1:0]   taken_cnt_d;

    assign opcode  = bus.insn[6:0];
    assign funct3  = bus.insn[14:12];
    assign is_b    = (opcode == OP_BRANCH);
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);

    branch_cmp u_cmp (
        .funct3_i  (funct3),
        .rs1_i     (bus.rs1_data),
        .rs2_i     (bus.rs2_data),
        .cond_o    (cmp_cond),
        .illegal_o (cmp_illegal)
    );

    // Immediate extraction and JAL range check against the label width
    always_comb begin
        bi     = b_imm(bus.insn);
        ji     = j_imm(bus.insn);
        j_sext = {{11{ji[20]}}, ji};
        // Bits above the label's sign bit must all replicate it
        j_hi   = j_sext >>> (LABEL_W - 1);
        j_fits = (j_hi == '0) || (j_hi == '1);
    end

    // Next-cycle decision for the instruction currently on the bus
    always_comb begin
        dec_branch  = is_b & ~cmp_illegal;
        dec_zero    = is_b & ~cmp_illegal & cmp_cond;
        dec_jump    = is_jal & j_fits;
        dec_oor     = is_jal & ~j_fits;
        dec_illegal = (is_b & cmp_illegal) | is_jalr;
        dec_taken   = (dec_branch & dec_zero) | dec_jump;
        dec_label   = is_jal ? LABEL_W'(ji) : LABEL_W'($signed(bi));
    end

    // Saturating taken-redirect count
    always_comb begin
        taken_cnt_d = taken_cnt_q;
        if (taken_cnt_q != '1) begin
            taken_cnt_d = taken_cnt_q + 1'b1;
        end
    end

    // FSM with registered outputs; state moves to squash at the accept edge so the
    // slot presented during the redirect's output cycle is the first one discarded
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            sq_cnt_q    <= '0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            zero_q      <= 1'b0;
            flush_q     <= 1'b0;
            illegal_q   <= 1'b0;
            jal_oor_q   <= 1'b0;
            label_q     <= '0;
            taken_cnt_q <= '0;
        end else begin
            branch_q  <= 1'b0;
            jump_q    <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            jal_oor_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.insn_valid) begin
                        branch_q  <= dec_branch;
                        jump_q    <= dec_jump;
                        zero_q    <= dec_zero;
                        illegal_q <= dec_illegal;
                        jal_oor_q <= dec_oor;
                        // Label only changes when there is a redirect target to show
                        if (dec_branch || dec_jump) begin
                            label_q <= dec_label;
                        end
                        if (dec_taken) begin
                            state_q     <= StSquash;
                            sq_cnt_q    <= SQ_W'(SQUASH_CYC);
                            flush_q     <= 1'b1;
                            taken_cnt_q <= taken_cnt_d;
                        end
                    end
                end
                StSquash: begin
                    if (bus.insn_valid) begin
                        if (sq_cnt_q <= SQ_W'(1)) begin
                            state_q  <= StIdle;
                            sq_cnt_q <= '0;
                            flush_q  <= 1'b0;
                        end else begin
                            sq_cnt_q <= sq_cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    sq_cnt_q <= '0;
                    flush_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.branch    = branch_q;
    assign bus.jump      = jump_q;
    assign bus.zero      = zero_q;
    assign bus.flush     = flush_q;
    assign bus.illegal   = illegal_q;
    assign bus.jal_oor   = jal_oor_q;
    assign bus.label     = label_q;
    assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with hand-computed expected outputs.
module tb_branch_ctrl;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BEQ      = 32'h0C20_8263;
    localparam logic [31:0] BNE      = 32'h0C20_9263;
    localparam logic [31:0] BLT      = 32'h0C20_C263;
    localparam logic [31:0] BGE      = 32'h0C20_D263;
    localparam logic [31:0] BLTU     = 32'h0C20_E263;
    localparam logic [31:0] BGEU     = 32'h0C20_F263;
    localparam logic [31:0] B010     = 32'h0C20_A263;
    localparam logic [31:0] JAL800   = 32'h3200_006F;
    localparam logic [31:0] JAL8192  = 32'h0000_206F;
    localparam logic [31:0] JALM4    = 32'hFFDF_F06F;
    localparam logic [31:0] JALR     = 32'h0000_8067;
    localparam logic [31:0] NEG1     = 32'hFFFF_FFFF;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    branch_ctrl_if #(.LABEL_W(13), .CNT_W(16)) bus ();

    branch_ctrl #(.LABEL_W(13), .SQUASH_CYC(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse vector order: {branch, jump, zero, flush, illegal, jal_oor}
    task automatic check_p(input string tag, input logic [5:0] exp);
        check_eq(tag, 32'({bus.branch, bus.jump, bus.zero, bus.flush, bus.illegal, bus.jal_oor}),
                 32'(exp));
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic [31:0] a,
                         input logic [31:0] b);
        bus.insn       = i;
        bus.insn_valid = v;
        bus.rs1_data   = a;
        bus.rs2_data   = b;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        drive(NOP, 1'b0, 32'd0, 32'd0);
        #3;
        check_p("reset_pulses", 6'b000000);
        check_eq("reset_label", 32'(bus.label), 32'd0);
        check_eq("reset_cnt", 32'(bus.taken_cnt), 32'd0);
        tick();
        rst = 1'b1;

        // BEQ taken, then two valid wrong-path slots
        drive(BEQ, 1'b1, 32'd5, 32'd5);
        tick();
        check_p("beq_taken", 6'b101100);
        check_eq("beq_label", 32'(bus.label), 32'd196);
        check_eq("beq_cnt", 32'(bus.taken_cnt), 32'd1);
        drive(BEQ, 1'b1, 32'd5, 32'd5);
        tick();
        check_p("beq_slot1", 6'b000100);
        drive(NOP, 1'b1, 32'd0, 32'd0);
        tick();
        check_p("beq_slot2", 6'b000000);

        // Back-to-back non-taken branches, then signed BLT taken
        drive(BNE, 1'b1, 32'd5, 32'd5);
        tick();
        check_p("bne_nt", 6'b100000);
        check_eq("bne_label", 32'(bus.label), 32'd196);
        drive(BLTU, 1'b1, NEG1, 32'd1);
        tick();
        check_p("bltu_nt", 6'b100000);
        drive(BGE, 1'b1, NEG1, 32'd1);
        tick();
        check_p("bge_nt", 6'b100000);
        drive(BLT, 1'b1, NEG1, 32'd1);
        tick();
        check_p("blt_taken", 6'b101100);
        check_eq("blt_cnt", 32'(bus.taken_cnt), 32'd2);

        // Invalid cycles during squash must not consume slots
        for (int k = 0; k < 3; k++) begin
            drive(NOP, 1'b0, 32'd0, 32'd0);
            tick();
            check_p("sq_idle_gap", 6'b000100);
        end
        drive(NOP, 1'b1, 32'd0, 32'd0);
        tick();
        check_p("sq_gap_slot1", 6'b000100);
        drive(NOP, 1'b1, 32'd0, 32'd0);
        tick();
        check_p("sq_gap_slot2", 6'b000000);
        drive(NOP, 1'b0, 32'd0, 32'd0);
        tick();
        check_p("nop_quiet", 6'b000000);
        check_eq("nop_label_hold", 32'(bus.label), 32'd196);

        // JAL in range, out of range, negative
        drive(JAL800, 1'b1, 32'd0, 32'd0);
        tick();
        check_p("jal800", 6'b010100);
        check_eq("jal800_label", 32'(bus.label), 32'd800);
        check_eq("jal800_cnt", 32'(bus.taken_cnt), 32'd3);
        drive(NOP, 1'b1, 32'd0, 32'd0);
        tick();
        drive(NOP, 1'b1, 32'd0, 32'd0);
        tick();
        check_p("jal800_done", 6'b000000);
        drive(JAL8192, 1'b1, 32'd0, 32'd0);
        tick();
        check_p("jal_oor", 6'b000001);
        check_eq("jal_oor_label", 32'(bus.label), 32'd800);
        check_eq("jal_oor_cnt", 32'(bus.taken_cnt), 32'd3);
        drive(JALM4, 1'b1, 32'd0, 32'd0);
        tick();
        check_p("jal_m4", 6'b010100);
        check_eq("jal_m4_label", 32'(bus.label), 32'h1FFC);
        drive(NOP, 1'b1, 32'd0, 32'd0);
        tick();
        drive(NOP, 1'b1, 32'd0, 32'd0);
        tick();

        // Illegal encodings
        drive(B010, 1'b1, 32'd5, 32'd5);
        tick();
        check_p("b010_illegal", 6'b000010);
        drive(JALR, 1'b1, 32'd0, 32'd0);
        tick();
        check_p("jalr_illegal", 6'b000010);
        check_eq("illegal_label_hold", 32'(bus.label), 32'h1FFC);

        // BGEU taken, then reset in the middle of the squash window
        drive(BGEU, 1'b1, NEG1, 32'd1);
        tick();
        check_p("bgeu_taken", 6'b101100);
        check_eq("bgeu_cnt", 32'(bus.taken_cnt), 32'd5);
        drive(NOP, 1'b1, 32'd0, 32'd0);
        tick();
        check_p("bgeu_slot1", 6'b000100);
        #2;
        rst = 1'b0;
        #1;
        check_p("rst_mid_sq", 6'b000000);
        check_eq("rst_mid_cnt", 32'(bus.taken_cnt), 32'd0);
        check_eq("rst_mid_label", 32'(bus.label), 32'd0);
        tick();
        rst = 1'b1;
        drive(BEQ, 1'b1, 32'd5, 32'd6);
        tick();
        check_p("post_rst_accept", 6'b100000);
        check_eq("post_rst_label", 32'(bus.label), 32'd196);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Decode-side partner of the fetch unit `pc`. It consumes the fetched instruction, resolves RV32I conditional branches and JAL, and drives `pc`'s redirect inputs: branch, jump, zero, label.
- Registers one decision per accepted instruction.
- After a taken redirect it squashes the wrong-path instructions already fetched.
- Sits between `pc` and the register file / datapath.

Parameters:
- LABEL_W, 13, width of signed byte-offset label (matches B-type immediate)
- SQUASH_CYC, 2, wrong-path fetch slots discarded after each taken redirect (1..7)
- CNT_W, 16, width of taken-redirect statistics counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- insn  input  32  instruction from `pc`
- insn_valid  input  1  insn is valid this cycle
- rs1_data  input  32  value of register insn[19:15]
- rs2_data  input  32  value of register insn[24:20]
- branch  output  1  conditional-branch instruction decoded (pulse)
- jump  output  1  JAL decoded (pulse)
- zero  output  1  branch condition true (pulse, meaningful with branch)
- label  output  LABEL_W  signed byte offset for redirect
- flush  output  1  high while wrong-path slots are being discarded
- illegal  output  1  B-type with funct3 010/011, or JALR (unsupported) (pulse)
- jal_oor  output  1  JAL offset does not fit LABEL_W; jump suppressed (pulse)
- taken_cnt  output  CNT_W  count of taken redirects, saturating

Behaviour:
- Reset (rst=0, async): all outputs 0, label 0, state IDLE, squash counter 0, taken_cnt 0. Applies immediately, including mid-squash.
- Accept: at a rising edge, insn_valid=1 and state IDLE.
- Latency: all outputs for an accepted insn are registered and valid in the cycle after acceptance, for exactly one cycle. Otherwise outputs are 0; label holds its last value.
- Decode by opcode insn[6:0]:
  - 1100011 (B-type): branch=1. label = {insn[31],insn[7],insn[30:25],insn[11:8],1'b0}. zero per funct3:
    - 000 BEQ: rs1==rs2
    - 001 BNE: rs1!=rs2
    - 100 BLT: signed <
    - 101 BGE: signed >=
    - 110 BLTU: unsigned <
    - 111 BGEU: unsigned >=
    - 010/011: branch=0, zero=0, illegal=1.
  - 1101111 (JAL): 21-bit imm = {insn[31],insn[19:12],insn[20],insn[30:21],0}. If imm[20:LABEL_W-1] is all-0 or all-1: jump=1, label=imm[LABEL_W-1:0]. Otherwise jump=0, jal_oor=1.
  - 1100111 (JALR): illegal=1, no redirect.
  - Any other opcode: all pulses 0.
- Taken redirect: (branch & zero) | jump in the output cycle.
- FSM IDLE -> SQUASH:
  - Entered on a taken redirect; counter loaded with SQUASH_CYC.
  - In SQUASH: flush=1. Each cycle with insn_valid=1 decrements the counter, and that insn is discarded (no outputs).
  - SQUASH -> IDLE when the counter reaches 0. The next valid insn is accepted.
  - insn_valid=0 cycles in SQUASH do not decrement.
- taken_cnt increments on each taken redirect and saturates at all-ones.
- Back-to-back non-taken branches are accepted every cycle with no bubbles.
- A redirect and the next insn_valid in the same cycle: that insn is the first squashed slot.
- Comparisons are full 32-bit. Label sign-extension and addition are `pc`'s job.

Decomposition:
- Shared package `rv_pkg`: opcode constants (OP_BRANCH, OP_JAL, OP_JALR), funct3 constants (F3_BEQ..F3_BGEU), FSM state encoding.
- One natural sub-module: `branch_cmp` (combinational: funct3, rs1, rs2 -> cond, illegal).
- Immediate extraction and the FSM stay in branch_ctrl.

Test Plan:
- Reset: rst=0 asserted mid-SQUASH with flush=1 -> all outputs 0 immediately, taken_cnt=0. After release, the next valid insn is accepted with no squash.
- BEQ taken: insn 0x0C208263 (beq x1,x2,+196), rs1=rs2=5 -> next cycle branch=1, zero=1, label=196. Then flush=1 for 2 valid slots, taken_cnt=1.
- BNE not taken: same encoding with funct3=001 (0x0C209263), rs1=rs2=5 -> branch=1, zero=0, label=196, no flush. The following insn is accepted the next cycle.
- Signed vs unsigned: BLT then BLTU with rs1=0xFFFFFFFF, rs2=1 -> zero=1 for BLT, zero=0 for BLTU.
- JAL: insn 0x3200006F (jal x0,+800) -> jump=1, label=800, flush for 2 slots. jal +8192 -> jal_oor=1, jump=0, no flush.
- Illegal/squash timing: funct3=010 B-type -> illegal=1, branch=0. Taken redirect with insn_valid low for 3 cycles during SQUASH -> flush stays 1 until 2 valid slots have been discarded.
